// File: rtl/decode_stage.sv
// decode_stage: requests one RV32I word at a time from fetch, decodes fields and immediate,
// holds the result under a valid/accept handshake and redirects fetch on JAL.
module decode_stage #(
   parameter bit JUMP_REDIRECT = 1'b1
) (
   input  logic        clockIn,
   input  logic        resetIn,
   input  logic        flushIn,
   output logic        startOut,
   input  logic [31:0] instructionIn,
   input  logic [31:0] addressIn,
   input  logic        readyIn,
   output logic [31:0] jumpAddressOut,
   output logic        jumpLatchOut,
   output logic [6:0]  opcodeOut,
   output logic [4:0]  rdOut,
   output logic [2:0]  funct3Out,
   output logic [4:0]  rs1Out,
   output logic [4:0]  rs2Out,
   output logic [6:0]  funct7Out,
   output logic [31:0] immediateOut,
   output logic [31:0] addressOut,
   output logic        illegalOut,
   output logic        validOut,
   input  logic        acceptIn
);
   typedef enum logic [1:0] {S_BOOT, S_ISSUE, S_WAIT, S_FULL} state_t;
   state_t state, state_nx;
   logic drop, drop_nx, capture, is_jal, illegal;
   logic [31:0] inst_q, imm, imm_j;
   always_ff @(posedge clockIn or negedge resetIn)
      if (!resetIn) begin
         state          <= S_BOOT;
         drop           <= 1'b0;
         startOut       <= 1'b0;
         validOut       <= 1'b0;
         jumpLatchOut   <= 1'b0;
         jumpAddressOut <= '0;
         inst_q         <= '0;
         immediateOut   <= '0;
         addressOut     <= '0;
         illegalOut     <= 1'b0;
      end else begin
         state        <= state_nx;
         drop         <= drop_nx;
         startOut     <= (state_nx == S_ISSUE);
         validOut     <= (state_nx == S_FULL);
         jumpLatchOut <= capture && is_jal && JUMP_REDIRECT;
         if (capture) begin
            inst_q       <= instructionIn;
            immediateOut <= imm;
            addressOut   <= addressIn;
            illegalOut   <= illegal;
            if (is_jal && JUMP_REDIRECT)
               jumpAddressOut <= addressIn + {{2{imm_j[31]}}, imm_j[31:2]};
         end
      end
   // a flush while a request is in flight only marks its response for discard
   always_comb begin
      state_nx = state;
      drop_nx  = drop;
      case (state)
         S_BOOT:  state_nx = S_ISSUE;
         S_ISSUE: begin
            state_nx = S_WAIT;
            drop_nx  = drop | flushIn;
         end
         S_WAIT: begin
            state_nx = readyIn ? ((drop || flushIn) ? S_ISSUE : S_FULL) : S_WAIT;
            drop_nx  = readyIn ? 1'b0 : (drop | flushIn);
         end
         S_FULL:  state_nx = (acceptIn || flushIn) ? S_ISSUE : S_FULL;
      endcase
   end
   always_comb begin
      capture = (state == S_WAIT) && readyIn && !drop && !flushIn;
      is_jal  = (instructionIn[6:0] == 7'b1101111);
      imm_j   = {{11{instructionIn[31]}}, instructionIn[31], instructionIn[19:12],
                 instructionIn[20], instructionIn[30:21], 1'b0};
      imm     = '0;
      illegal = 1'b0;
      case (instructionIn[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
            imm = {{20{instructionIn[31]}}, instructionIn[31:20]};
         7'b0100011:
            imm = {{20{instructionIn[31]}}, instructionIn[31:25], instructionIn[11:7]};
         7'b1100011:
            imm = {{19{instructionIn[31]}}, instructionIn[31], instructionIn[7],
                   instructionIn[30:25], instructionIn[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm = {instructionIn[31:12], 12'b0};
         7'b1101111: imm = imm_j;
         7'b0110011: imm = '0;
         default:    illegal = 1'b1;
      endcase
   end
   assign opcodeOut = inst_q[6:0];
   assign rdOut     = inst_q[11:7];
   assign funct3Out = inst_q[14:12];
   assign rs1Out    = inst_q[19:15];
   assign rs2Out    = inst_q[24:20];
   assign funct7Out = inst_q[31:25];
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed fetch responses with hand-computed decodes, checked by a
// scoreboard monitor that pops an expectation each time validOut rises.
module tb_decode_stage;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ready = 1'b0, accept = 1'b0;
   logic [31:0] instr = '0, addr = '0;
   logic        start, jl, ill, valid, start0, jl0, ill0, valid0;
   logic [31:0] jaddr, imm, aout, jaddr0, imm0, aout0;
   logic [6:0]  opc, f7, opc0, f70;
   logic [4:0]  rd, rs1, rs2, rd0, rs10, rs20;
   logic [2:0]  f3, f30;
   int checks = 0, errors = 0;
   typedef struct {logic [31:0] ins, a, imm; logic ill, jl; logic [31:0] ja;} exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   decode_stage u1 (
      .clockIn(clk), .resetIn(rst_n), .flushIn(flush), .startOut(start),
      .instructionIn(instr), .addressIn(addr), .readyIn(ready),
      .jumpAddressOut(jaddr), .jumpLatchOut(jl), .opcodeOut(opc), .rdOut(rd),
      .funct3Out(f3), .rs1Out(rs1), .rs2Out(rs2), .funct7Out(f7),
      .immediateOut(imm), .addressOut(aout), .illegalOut(ill), .validOut(valid),
      .acceptIn(accept));

   decode_stage #(.JUMP_REDIRECT(1'b0)) u0 (
      .clockIn(clk), .resetIn(rst_n), .flushIn(flush), .startOut(start0),
      .instructionIn(instr), .addressIn(addr), .readyIn(ready),
      .jumpAddressOut(jaddr0), .jumpLatchOut(jl0), .opcodeOut(opc0), .rdOut(rd0),
      .funct3Out(f30), .rs1Out(rs10), .rs2Out(rs20), .funct7Out(f70),
      .immediateOut(imm0), .addressOut(aout0), .illegalOut(ill0), .validOut(valid0),
      .acceptIn(accept));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_start"}, start, 0);
      chk({n, "_valid"}, valid, 0);
      chk({n, "_jl"}, jl, 0);
      chk({n, "_jaddr"}, jaddr, 0);
      chk({n, "_imm"}, imm, 0);
      chk({n, "_addr"}, aout, 0);
      chk({n, "_ill"}, ill, 0);
      chk({n, "_opc"}, opc, 0);
      chk({n, "_f7"}, f7, 0);
   endtask

   task automatic wait_start();
      int n = 0;
      while (!start && n < 20) begin
         step();
         n++;
      end
      chk("start_seen", start, 1);
   endtask

   // entered at the ISSUE-cycle negedge; accept is waved during WAIT and must be ignored
   task automatic respond(input logic [31:0] ins, input logic [31:0] a, input int lat,
                          input logic fl);
      step();
      chk("start_pulse", start, 0);
      accept = 1'b1;
      repeat (lat - 1) step();
      accept = 1'b0;
      instr = ins;
      addr = a;
      ready = 1'b1;
      flush = fl;
      step();
      ready = 1'b0;
      flush = 1'b0;
   endtask

   task automatic consume(input int hold, input logic [31:0] a, input logic fl);
      int n = 0;
      while (!valid && n < 10) begin
         step();
         n++;
      end
      chk("valid_seen", valid, 1);
      for (int i = 0; i < hold; i++) begin
         chk("hold_start", start, 0);
         chk("hold_valid", valid, 1);
         chk("hold_addr", aout, a);
         step();
      end
      if (fl) flush = 1'b1;
      else accept = 1'b1;
      step();
      flush = 1'b0;
      accept = 1'b0;
      chk("start_after", start, 1);
      chk("valid_after", valid, 0);
   endtask

   task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] im,
                      input logic il, input logic j, input logic [31:0] ja,
                      input int lat, input int hold, input logic fl);
      exp_t e;
      e = '{ins, a, im, il, j, ja};
      wait_start();
      q.push_back(e);
      respond(ins, a, lat, 1'b0);
      consume(hold, a, fl);
   endtask

   initial begin : monitor
      exp_t e;
      logic v_prev, rise, exp_jl;
      v_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rise = valid && !v_prev;
         exp_jl = 1'b0;
         if (rise) begin
            if (q.size() == 0) chk("unexpected_valid", valid, 0);
            else begin
               e = q.pop_front();
               exp_jl = e.jl;
               chk("opcode", opc, e.ins[6:0]);
               chk("rd", rd, e.ins[11:7]);
               chk("funct3", f3, e.ins[14:12]);
               chk("rs1", rs1, e.ins[19:15]);
               chk("rs2", rs2, e.ins[24:20]);
               chk("funct7", f7, e.ins[31:25]);
               chk("imm", imm, e.imm);
               chk("addr_out", aout, e.a);
               chk("illegal", ill, e.ill);
               if (e.jl) chk("jump_addr", jaddr, e.ja);
            end
         end
         chk("jump_latch", jl, exp_jl);
         chk("jump_latch_off", jl0, 0);
         v_prev = valid;
      end
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : stim
      repeat (2) step();
      chk_zero("reset");
      rst_n = 1'b1;
      #1 chk("boot_start", start, 0);
      step();
      chk("boot_to_issue", start, 1);
      run(32'h00500093, 32'd4, 32'd5, 1'b0, 1'b0, 32'd0, 2, 5, 1'b0);
      run(32'hFF9FF0EF, 32'd10, 32'hFFFFFFF8, 1'b0, 1'b1, 32'd8, 1, 0, 1'b0);
      run(32'h00112623, 32'd20, 32'd12, 1'b0, 1'b0, 32'd0, 3, 0, 1'b0);
      run(32'hFE112E23, 32'd21, 32'hFFFFFFFC, 1'b0, 1'b0, 32'd0, 1, 1, 1'b0);
      run(32'hFE000EE3, 32'd22, 32'hFFFFFFFC, 1'b0, 1'b0, 32'd0, 1, 0, 1'b0);
      run(32'h123450B7, 32'd23, 32'h12345000, 1'b0, 1'b0, 32'd0, 2, 0, 1'b0);
      run(32'h002081B3, 32'd24, 32'd0, 1'b0, 1'b0, 32'd0, 1, 0, 1'b0);
      run(32'h00000000, 32'd25, 32'd0, 1'b1, 1'b0, 32'd0, 1, 0, 1'b0);
      run(32'hFFFFFFFF, 32'd26, 32'd0, 1'b1, 1'b0, 32'd0, 1, 0, 1'b0);
      run(32'h0080006F, 32'hFFFFFFFF, 32'd8, 1'b0, 1'b1, 32'd1, 2, 0, 1'b1);
      // flush in ISSUE: the JAL response must vanish without a redirect
      wait_start();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("drop_start", start, 0);
      instr = 32'h0000006F;
      addr = 32'h20;
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("drop_valid", valid, 0);
      chk("drop_jl", jl, 0);
      chk("drop_reissue", start, 1);
      // flush together with the response in WAIT
      wait_start();
      step();
      instr = 32'h00500093;
      addr = 32'h30;
      ready = 1'b1;
      flush = 1'b1;
      step();
      ready = 1'b0;
      flush = 1'b0;
      chk("flush_ready_valid", valid, 0);
      chk("flush_ready_reissue", start, 1);
      run(32'h00A00113, 32'd40, 32'd10, 1'b0, 1'b0, 32'd0, 1, 0, 1'b0);
      // reset in the middle of a request
      wait_start();
      step();
      rst_n = 1'b0;
      #1 chk_zero("mid_reset");
      step();
      rst_n = 1'b1;
      #1 chk("reboot_start", start, 0);
      step();
      chk("reboot_issue", start, 1);
      run(32'hFFF00093, 32'd50, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 1, 0, 1'b0);
      repeat (3) step();
      chk("scoreboard_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
